fcmp_pipe: RTL
==============

// Module: fcmp_pipe
// PURPOSE
//  Parametrised, pipelined single-precision compare unit; successor of the fixed 1-stage fless.
//  Evaluates x1<x2, x1<=x2 or x1==x2 (per-op mode) and flags unordered (NaN) inputs.
//  Carries an opaque tag (writeback flag + register address) alongside the data.
//  Valid/ready handshake on both sides. Sits in the FPU between issue and the integer writeback mux.
// PARAMETERS
//  NSTAGE  2  pipeline depth = latency in cycles; legal 1..4
//  TAGW    6  tag width ({flag, add[4:0]} by default)
// PORTS
//  clk        in   1     clock; all state on posedge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     x1/x2/mode/tag_in valid this cycle
//  in_ready   out  1     unit accepts a beat this cycle
//  x1         in   32    IEEE-754 single operand A
//  x2         in   32    IEEE-754 single operand B
//  mode       in   2     fpu_pkg::cmp_mode_t: 0=LT 1=LE 2=EQ 3=reserved (result 0)
//  tag_in     in   TAGW  opaque tag
//  out_valid  out  1     y/unord/tag_out valid
//  out_ready  in   1     consumer takes the result this cycle
//  y          out  1     comparison result
//  unord      out  1     either operand NaN (exp==255, mant!=0)
//  tag_out    out  TAGW  tag_in of the same beat, unchanged
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all stage valid bits cleared; out_valid=0, y=0, unord=0, tag_out=0.
//    Data registers also cleared. Reset mid-operation discards every in-flight beat; no output appears.
//  - Global advance enable: adv = !v[NSTAGE] || out_ready. in_ready = adv && !rst (combinational).
//  - Handshake: a beat is accepted when in_valid && in_ready.
//    A result is consumed when out_valid && out_ready.
//    While out_valid && !out_ready, every stage holds and y/unord/tag_out stay stable.
//  - Latency: exactly NSTAGE cycles from acceptance to out_valid when adv stays 1. Throughput: 1 beat/cycle.
//    Bubbles (in_valid=0) propagate as v=0; they are not collapsed.
//  - Simultaneous consume and accept in one cycle: both take effect; no beat is lost or duplicated.
//  - Arithmetic (stage 1, combinational core):
//    * Denormal flush: exp==0 -> operand treated as +0, so -0 == +0 and denormals == 0.
//    * Ordering key: k = sign ? ~bits : bits | 32'h8000_0000. Unsigned compare of kA and kB.
//    * lt = kA<kB, eq = kA==kB, le = lt|eq.
//    * Infinities order naturally.
//    * NaN on either side: unord=1 and y=0 for every mode.
//    * mode==3: y=0, unord still computed.
//  - Stages 2..NSTAGE are register-only retiming of {y, unord, tag}.
//    With NSTAGE=1 the core output is registered once.
//  - Tag passes through bit-exact. tag_in is ignored when in_valid=0.
// STRUCTURE
//  - fpu_pkg: cmp_mode_t enum (CMP_LT, CMP_LE, CMP_EQ, CMP_RSV), FP32_EXP_MAX=8'hFF, fp32 field struct.
//    The package is shared with the other FPU units.
//  - Sub-module fcmp_core (combinational): x1, x2, mode -> y, unord. Contains flush, key and compare.
//  - Top: valid/data shift pipeline of depth NSTAGE with the global stall enable above.
// TESTING
//  1. rst=1 for 2 cycles, then rst=0 -> out_valid=0, in_ready=1, y=0, tag_out=0.
//  2. NSTAGE=2, out_ready=1, x1=3F800000 (1.0), x2=40000000 (2.0), LT, tag=6'h2A
//     -> 2 cycles later out_valid=1, y=1, unord=0, tag_out=2A. Swapped operands -> y=0.
//  3. Zeros/denormals: x1=80000000, x2=00000000, EQ -> y=1.
//     x1=00000001, x2=00000000, LT -> y=0. Same pair with LE -> y=1.
//  4. Negatives and NaN: x1=C0000000 (-2.0), x2=BF800000 (-1.0), LT -> y=1.
//     x1=7FC00000, any x2, any mode -> y=0, unord=1.
//  5. Back-pressure: stream 8 beats (tags 0..7) with out_ready toggling 1,0,0,1,...
//     -> tags appear in order 0..7, none lost or duplicated; outputs stable while stalled;
//     in_ready=0 exactly when v[NSTAGE]&&!out_ready.
//  6. Random soak over NSTAGE in {1,2,4}: 1e6 random/edge operands
//     (exp 0,1,254,255; mant 0, 1, all-ones) vs. shortreal model with denormal flush
//     -> zero mismatches; rst asserted mid-stream -> no output for in-flight beats.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types: compare modes and fp32 field layout
package fpu_pkg;

    typedef enum logic [1:0] {
        CMP_LT  = 2'd0,
        CMP_LE  = 2'd1,
        CMP_EQ  = 2'd2,
        CMP_RSV = 2'd3
    } cmp_mode_t;

    localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

endpackage

// File: rtl/fcmp_core.sv
// rtl/fcmp_core.sv - combinational fp32 compare with denormal flush and NaN detect
module fcmp_core
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [1:0]  mode,
    output logic        y,
    output logic        unord
);

    fp32_t       a;
    fp32_t       b;
    logic [31:0] flat_a;
    logic [31:0] flat_b;
    logic [31:0] key_a;
    logic [31:0] key_b;
    logic        neg_a;
    logic        neg_b;
    logic        lt;
    logic        eq;

    assign a = fp32_t'(x1);
    assign b = fp32_t'(x2);

    // Zero exponent collapses to +0, so -0 and every denormal compare equal to +0.
    assign neg_a  = a.sign && (a.exp != 8'd0);
    assign neg_b  = b.sign && (b.exp != 8'd0);
    assign flat_a = (a.exp == 8'd0) ? 32'd0 : x1;
    assign flat_b = (b.exp == 8'd0) ? 32'd0 : x2;

    // Sign-magnitude to monotonic unsigned key: negatives inverted, positives offset above them.
    assign key_a = neg_a ? ~flat_a : (flat_a | 32'h8000_0000);
    assign key_b = neg_b ? ~flat_b : (flat_b | 32'h8000_0000);

    assign lt = key_a < key_b;
    assign eq = key_a == key_b;

    assign unord = ((a.exp == FP32_EXP_MAX) && (a.mant != 23'd0)) ||
                   ((b.exp == FP32_EXP_MAX) && (b.mant != 23'd0));

    always_comb begin
        y = 1'b0;
        if (!unord) begin
            case (cmp_mode_t'(mode))
                CMP_LT:  y = lt;
                CMP_LE:  y = lt | eq;
                CMP_EQ:  y = eq;
                default: y = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - pipelined fp32 compare with tag passthrough and valid/ready stall
module fcmp_pipe
    import fpu_pkg::*;
#(
    parameter int NSTAGE = 2,
    parameter int TAGW   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     x1,
    input  logic [31:0]     x2,
    input  logic [1:0]      mode,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            y,
    output logic            unord,
    output logic [TAGW-1:0] tag_out
);

    localparam int DW = TAGW + 2;

    logic            core_y;
    logic            core_unord;
    logic            adv;
    logic [NSTAGE:1] v;
    logic [DW-1:0]   pipe_q [1:NSTAGE];

    fcmp_core u_core (
        .x1    (x1),
        .x2    (x2),
        .mode  (mode),
        .y     (core_y),
        .unord (core_unord)
    );

    // One enable for the whole pipe: a full output slot that is not taken freezes every stage.
    assign adv      = !v[NSTAGE] || out_ready;
    assign in_ready = adv && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int i = 1; i <= NSTAGE; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (adv) begin
            v[1]      <= in_valid;
            pipe_q[1] <= in_valid ? {core_y, core_unord, tag_in} : '0;
            for (int i = 2; i <= NSTAGE; i++) begin
                v[i]      <= v[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign out_valid = v[NSTAGE];
    assign y         = pipe_q[NSTAGE][DW-1];
    assign unord     = pipe_q[NSTAGE][DW-2];
    assign tag_out   = pipe_q[NSTAGE][TAGW-1:0];

endmodule
